// File: rtl/layer_4_input_packer.sv
// Packs a channel-interleaved sample stream into one wide word per pixel and
// tracks pixel position within a frame, flagging frame end and framing errors.
module layer_4_input_packer #(
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_CH        = 32,
    parameter int DATA_IN_WIDTH = 1024,
    parameter int IMG_SIZE      = 104
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic [DATA_WIDTH-1:0]    s_data,
    input  logic                     s_valid,
    input  logic                     s_sof,
    output logic                     s_ready,
    output logic [DATA_IN_WIDTH-1:0] data_out,
    output logic                     valid_out,
    output logic                     frame_done,
    output logic                     sof_err
);

    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int NUM_PIX = IMG_SIZE * IMG_SIZE;
    localparam int PIX_W   = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;

    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(NUM_PIX - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PACK = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                               state_q, state_d;
    logic [CH_W-1:0]                      ch_cnt_q, ch_cnt_d;
    logic [PIX_W-1:0]                     pix_cnt_q, pix_cnt_d;
    logic [NUM_CH-1:0][DATA_WIDTH-1:0]    staging_q, staging_d;
    logic [DATA_IN_WIDTH-1:0]             data_out_q, data_out_d;
    logic                                 valid_q, valid_d;
    logic                                 frame_done_q, frame_done_d;
    logic                                 sof_err_q, sof_err_d;
    logic                                 accept;

    assign s_ready    = (state_q != DONE);
    assign accept     = s_valid && s_ready;
    assign data_out   = data_out_q;
    assign valid_out  = valid_q;
    assign frame_done = frame_done_q;
    assign sof_err    = sof_err_q;

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        ch_cnt_d     = ch_cnt_q;
        pix_cnt_d    = pix_cnt_q;
        staging_d    = staging_q;
        data_out_d   = data_out_q;
        valid_d      = 1'b0;
        frame_done_d = 1'b0;
        sof_err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (s_sof) begin
                        staging_d[0] = s_data;
                        ch_cnt_d     = CH_W'(1);
                        pix_cnt_d    = '0;
                        state_d      = PACK;
                    end else begin
                        sof_err_d = 1'b1;
                    end
                end
            end
            PACK: begin
                if (accept) begin
                    if (s_sof) begin
                        // Resync: abandon the partial pixel and restart the frame here.
                        staging_d[0] = s_data;
                        ch_cnt_d     = CH_W'(1);
                        pix_cnt_d    = '0;
                        sof_err_d    = 1'b1;
                    end else begin
                        staging_d[ch_cnt_q] = s_data;
                        if (ch_cnt_q == LAST_CH) begin
                            data_out_d = staging_d;
                            valid_d    = 1'b1;
                            ch_cnt_d   = '0;
                            if (pix_cnt_q == LAST_PIX) begin
                                frame_done_d = 1'b1;
                                pix_cnt_d    = '0;
                                state_d      = DONE;
                            end else begin
                                pix_cnt_d = pix_cnt_q + PIX_W'(1);
                            end
                        end else begin
                            ch_cnt_d = ch_cnt_q + CH_W'(1);
                        end
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the staging register is cleared on reset too, so no stale channel data survives an abort.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q      <= IDLE;
            ch_cnt_q     <= '0;
            pix_cnt_q    <= '0;
            staging_q    <= '0;
            data_out_q   <= '0;
            valid_q      <= 1'b0;
            frame_done_q <= 1'b0;
            sof_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ch_cnt_q     <= ch_cnt_d;
            pix_cnt_q    <= pix_cnt_d;
            staging_q    <= staging_d;
            data_out_q   <= data_out_d;
            valid_q      <= valid_d;
            frame_done_q <= frame_done_d;
            sof_err_q    <= sof_err_d;
        end
    end

endmodule

// File: tb/tb_layer_4_input_packer.sv
// Self-checking bench for layer_4_input_packer: directed tables, corner-case
// sequences and random traffic compared against a queue-based pixel model.
module tb_layer_4_input_packer;

    localparam int DW    = 32;
    localparam int NCH   = 32;
    localparam int DIW   = 1024;
    localparam int IMG   = 4;
    localparam int FRAME = IMG * IMG;

    logic           Clk;
    logic           Rst;
    logic [DW-1:0]  s_data;
    logic           s_valid;
    logic           s_sof;
    logic           s_ready;
    logic [DIW-1:0] data_out;
    logic           valid_out;
    logic           frame_done;
    logic           sof_err;

    layer_4_input_packer #(
        .DATA_WIDTH    (DW),
        .NUM_CH        (NCH),
        .DATA_IN_WIDTH (DIW),
        .IMG_SIZE      (IMG)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_sof      (s_sof),
        .s_ready    (s_ready),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .frame_done (frame_done),
        .sof_err    (sof_err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: a frame is "open" after an accepted sof; samples collect
    // in a queue and a pixel is emitted whenever the queue holds NCH samples.
    logic [DW-1:0]  m_cur[$];
    logic           m_in_frame;
    logic           m_done;
    int             m_pix;
    logic [DIW-1:0] m_data;
    logic           m_valid, m_fd, m_err, m_ready;

    typedef struct {
        logic          v;
        logic          sof;
        logic [DW-1:0] d;
        logic          exp_err;
        logic          exp_valid;
        logic          exp_ready;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic check_data(input string name, input logic [DIW-1:0] act, input logic [DIW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else begin
            int lane;
            lane = 0;
            for (int k = NCH - 1; k >= 0; k--)
                if (act[k*DW +: DW] !== exp[k*DW +: DW]) lane = k;
            $display("FAIL %s: lane %0d got %08h expected %08h at %0t",
                     name, lane, act[lane*DW +: DW], exp[lane*DW +: DW], $time);
        end
    endtask

    task automatic model_reset();
        m_cur.delete();
        m_in_frame = 1'b0;
        m_done     = 1'b0;
        m_pix      = 0;
        m_data     = '0;
        m_valid    = 1'b0;
        m_fd       = 1'b0;
        m_err      = 1'b0;
        m_ready    = 1'b1;
    endtask

    task automatic model_step(input logic v, input logic sof, input logic [DW-1:0] d);
        m_valid = 1'b0;
        m_fd    = 1'b0;
        m_err   = 1'b0;
        if (m_done) begin
            m_done = 1'b0;
        end else if (v) begin
            if (sof) begin
                m_err = m_in_frame;
                m_cur.delete();
                m_cur.push_back(d);
                m_pix      = 0;
                m_in_frame = 1'b1;
            end else if (!m_in_frame) begin
                m_err = 1'b1;
            end else begin
                m_cur.push_back(d);
                if (m_cur.size() == NCH) begin
                    for (int k = 0; k < NCH; k++) m_data[k*DW +: DW] = m_cur[k];
                    m_cur.delete();
                    m_valid = 1'b1;
                    m_pix++;
                    if (m_pix == FRAME) begin
                        m_fd       = 1'b1;
                        m_pix      = 0;
                        m_in_frame = 1'b0;
                        m_done     = 1'b1;
                    end
                end
            end
        end
        m_ready = !m_done;
    endtask

    task automatic cycle(input logic v, input logic sof, input logic [DW-1:0] d);
        s_valid = v;
        s_sof   = sof;
        s_data  = d;
        model_step(v, sof, d);
        @(posedge Clk);
        #1;
        check("valid_out", valid_out, m_valid);
        check("frame_done", frame_done, m_fd);
        check("sof_err", sof_err, m_err);
        check("s_ready", s_ready, m_ready);
        check_data("data_out", data_out, m_data);
    endtask

    task automatic do_reset();
        Rst     = 1'b1;
        s_valid = 1'b0;
        s_sof   = 1'b0;
        s_data  = '0;
        repeat (2) @(posedge Clk);
        #1;
        model_reset();
        Rst = 1'b0;
        check("rst_valid_out", valid_out, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_sof_err", sof_err, 1'b0);
        check("rst_s_ready", s_ready, 1'b1);
        check_data("rst_data_out", data_out, '0);
    endtask

    vec_t           vecs[7];
    logic [DIW-1:0] ref_px;
    logic [DIW-1:0] new_px;
    int             pulses;
    int             fd_at;

    initial begin
        Rst     = 1'b1;
        s_valid = 1'b0;
        s_sof   = 1'b0;
        s_data  = '0;
        model_reset();

        for (int k = 0; k < NCH; k++) begin
            ref_px[k*DW +: DW] = 32'h3F80_0000 + 32'(k);
            new_px[k*DW +: DW] = 32'h0000_1000 + 32'(k);
        end

        // Framing vectors from IDLE: three stray samples, a gap, then sof and a resync.
        vecs[0] = '{1'b1, 1'b0, 32'h0000_0011, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{1'b0, 1'b0, 32'h0000_0022, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0033, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_0044, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 32'h0000_0055, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 32'h0000_0066, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 32'h0000_0077, 1'b1, 1'b0, 1'b1};

        do_reset();
        for (int i = 0; i < 7; i++) begin
            cycle(vecs[i].v, vecs[i].sof, vecs[i].d);
            check("tbl_sof_err", sof_err, vecs[i].exp_err);
            check("tbl_valid_out", valid_out, vecs[i].exp_valid);
            check("tbl_s_ready", s_ready, vecs[i].exp_ready);
        end

        // Single pixel, back-to-back samples.
        do_reset();
        for (int k = 0; k < NCH; k++) cycle(1'b1, k == 0, 32'h3F80_0000 + 32'(k));
        check("single_valid", valid_out, 1'b1);
        check("single_lane0", data_out[31:0], 32'h3F80_0000);
        check("single_lane31", data_out[1023:992], 32'h3F80_001F);
        check("single_fd", frame_done, 1'b0);
        cycle(1'b0, 1'b0, '0);
        check("single_pulse_end", valid_out, 1'b0);
        check_data("single_hold", data_out, ref_px);

        // Same pixel with two idle cycles between samples.
        do_reset();
        pulses = 0;
        for (int k = 0; k < NCH; k++) begin
            cycle(1'b1, k == 0, 32'h3F80_0000 + 32'(k));
            if (k < NCH - 1) begin
                if (valid_out) pulses++;
                cycle(1'b0, 1'b0, 32'hFFFF_FFFF);
                if (valid_out) pulses++;
                cycle(1'b0, 1'b1, 32'hFFFF_FFFF);
                if (valid_out) pulses++;
            end
        end
        check("gap_no_early_valid", pulses, 0);
        check("gap_valid", valid_out, 1'b1);
        check("gap_fd", frame_done, 1'b0);
        check_data("gap_data", data_out, ref_px);

        // Full frame of FRAME pixels, then a sample offered during the DONE cycle.
        do_reset();
        pulses = 0;
        fd_at  = -1;
        for (int p = 0; p < FRAME; p++) begin
            for (int c = 0; c < NCH; c++) begin
                cycle(1'b1, (p == 0) && (c == 0), {8'(p), 8'(c), 16'hA5A5});
                if (valid_out) pulses++;
                if (frame_done) fd_at = pulses;
            end
        end
        check("frame_pulses", pulses, FRAME);
        check("frame_fd_last", fd_at, FRAME);
        check("frame_done_ready", s_ready, 1'b0);
        cycle(1'b1, 1'b1, 32'hCAFE_F00D);
        check("frame_idle_ready", s_ready, 1'b1);
        check("frame_done_ignored", sof_err, 1'b0);
        cycle(1'b1, 1'b0, 32'h0000_0001);
        check("frame_idle_nosof_err", sof_err, 1'b1);

        // Resync at the 10th sample of pixel 2.
        do_reset();
        for (int s = 0; s < 2 * NCH; s++) cycle(1'b1, s == 0, 32'(s));
        for (int s = 0; s < 9; s++) cycle(1'b1, 1'b0, 32'h100 + 32'(s));
        cycle(1'b1, 1'b1, 32'hDEAD_BEEF);
        check("resync_err", sof_err, 1'b1);
        check("resync_no_valid", valid_out, 1'b0);
        for (int s = 0; s < NCH - 1; s++) cycle(1'b1, 1'b0, 32'h200 + 32'(s));
        check("resync_valid", valid_out, 1'b1);
        check("resync_lane0", data_out[31:0], 32'hDEAD_BEEF);
        check("resync_not_fd", frame_done, 1'b0);
        for (int p = 1; p < FRAME; p++)
            for (int c = 0; c < NCH; c++) cycle(1'b1, 1'b0, $urandom);
        check("resync_frame_done", frame_done, 1'b1);

        // Reset in the middle of a pixel.
        do_reset();
        for (int s = 0; s < 20; s++) cycle(1'b1, s == 0, 32'hBAD0_0000 + 32'(s));
        do_reset();
        pulses = 0;
        for (int k = 0; k < NCH; k++) begin
            cycle(1'b1, k == 0, 32'h0000_1000 + 32'(k));
            if (valid_out) pulses++;
        end
        check_data("midrst_data", data_out, new_px);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, '0);
            if (valid_out) pulses++;
        end
        check("midrst_pulses", pulses, 1);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            logic v, sf;
            v = ($urandom_range(9) < 7);
            if (!m_in_frame) sf = ($urandom_range(3) != 0);
            else             sf = ($urandom_range(199) == 0);
            cycle(v, sf, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/layer_4_input_packer.md
Name: layer_4_input_packer

Overview:
- Transmit end of the 1024-bit channel-packed feature-map interface consumed by the layer_4 featuremap blocks.
- Accepts a channel-interleaved 32-bit pixel stream from the layer_3 output buffer: channel 0..31 of pixel p, then pixel p+1.
- Assembles each group of NUM_CH words into one DATA_IN_WIDTH word, with a single-cycle valid_out strobe.
- Tracks pixel position within an IMG_SIZE x IMG_SIZE frame and flags the end of the frame.

Parameters:
- DATA_WIDTH, 32, width of one channel sample (IEEE-754 single).
- NUM_CH, 32, channels packed per output word.
- DATA_IN_WIDTH, 1024, output word width; must equal DATA_WIDTH*NUM_CH.
- IMG_SIZE, 104, frame width and height in pixels.

Ports:
- Clk  input  1  clock, all logic on rising edge.
- Rst  input  1  synchronous, active-high reset.
- s_data  input  DATA_WIDTH  channel sample.
- s_valid  input  1  s_data valid.
- s_sof  input  1  marks the first sample (pixel 0, channel 0) of a frame; qualified by s_valid.
- s_ready  output  1  packer accepts the sample this cycle.
- data_out  output  DATA_IN_WIDTH  packed pixel; channel k in bits [DATA_WIDTH*k+DATA_WIDTH-1 : DATA_WIDTH*k].
- valid_out  output  1  one-cycle strobe, data_out holds a new pixel.
- frame_done  output  1  one-cycle strobe, coincident with valid_out of the last pixel.
- sof_err  output  1  one-cycle strobe on a framing violation.

Behaviour:
- Clk is the only clock. Rst is synchronous, active-high.
- Reset (sampled high at a Clk edge, any state):
  - data_out=0, valid_out=0, frame_done=0, sof_err=0.
  - state=IDLE, ch_cnt=0, pix_cnt=0, staging register=0.
  - A partial pixel or frame in progress is discarded.
- Accept condition: accept = s_valid & s_ready.
- s_ready is 1 in IDLE and PACK and 0 in DONE. The downstream interface has no backpressure.
- Counters:
  - ch_cnt is $clog2(NUM_CH) bits, range 0..NUM_CH-1.
  - pix_cnt is $clog2(IMG_SIZE*IMG_SIZE) bits, range 0..IMG_SIZE*IMG_SIZE-1.
- States:
  - IDLE: accept with s_sof=1 stores s_data at channel 0, sets ch_cnt=1, pix_cnt=0, and goes to PACK. Accept with s_sof=0 drops the sample, pulses sof_err next cycle, and stays in IDLE.
  - PACK: accept with s_sof=0 writes s_data to the staging slot ch_cnt, then increments ch_cnt.
    - On the accept at ch_cnt==NUM_CH-1, at the next edge: data_out = {s_data, staging[NUM_CH-2:0]}, valid_out=1, ch_cnt=0, pix_cnt increments.
    - If pix_cnt was IMG_SIZE*IMG_SIZE-1, also frame_done=1, pix_cnt=0, and go to DONE.
  - PACK, accept with s_sof=1 (resync): sof_err pulses next cycle. The sample is stored as channel 0, ch_cnt=1, pix_cnt=0. No valid_out is produced for the aborted partial pixel.
  - DONE: lasts exactly one cycle (the cycle valid_out/frame_done are high), then unconditionally returns to IDLE. s_valid is ignored and nothing is accepted.
- Latency: valid_out rises the cycle after the accept of the NUM_CH-th sample.
- Gaps: s_valid low in any cycle leaves all counters and staging unchanged. Pixel assembly tolerates arbitrary gaps.
- valid_out, frame_done and sof_err are high for one cycle only.
- data_out holds its value until the next pixel completes.
- Staging is not cleared between pixels. Every slot is overwritten before use.
- Minimum pixel period is NUM_CH cycles, so valid_out is never high on back-to-back cycles when NUM_CH>1.

Test Plan:
- Reset check: hold Rst for 2 cycles, then release with s_valid=0 -> all outputs 0, s_ready=1.
- Single pixel: sof on the first sample, 32 back-to-back samples with value 0x3F800000+k for k=0..31 -> one cycle after the 32nd accept, valid_out=1 for one cycle; data_out[31:0]=0x3F800000, data_out[1023:992]=0x3F80001F.
- Gaps: same pixel with s_valid toggling 1,0,0,1,... -> identical data_out. valid_out occurs one cycle after the 32nd accepted sample; frame_done=0.
- Full frame, IMG_SIZE=4, 512 samples -> 16 valid_out pulses. frame_done=1 only with the 16th pulse. s_ready=0 for exactly that cycle, then IDLE.
- Framing errors:
  - 3 samples with s_sof=0 in IDLE -> 3 sof_err pulses, no valid_out.
  - s_sof at the 10th sample of pixel 2 -> sof_err pulse. The next valid_out appears 31 accepts later with that sample in bits [31:0], and pix_cnt restarts at 0.
- Reset mid-pixel: Rst after 20 samples, then a fresh sof plus 32 samples -> exactly one valid_out with the new data only; no residual output from the aborted pixel.
